// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide sequencer.
// Holds the execute-stage op codes, the sequencer FSM states and the
// alu_control codes presented to ALU_32 for each multi-cycle operation.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } md_state_e;

    localparam logic [3:0] ALU_CTL_MULT  = 4'b1000;
    localparam logic [3:0] ALU_CTL_MULTU = 4'b1001;
    localparam logic [3:0] ALU_CTL_DIV   = 4'b1010;
    localparam logic [3:0] ALU_CTL_DIVU  = 4'b1011;

    // True for the four op codes that occupy the ALU for many cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // ALU control code for a mul/div op; non-mul/div ops map to 0.
    function automatic logic [3:0] alu_ctl_for(input logic [2:0] op);
        case (op)
            MD_MULT:  return ALU_CTL_MULT;
            MD_MULTU: return ALU_CTL_MULTU;
            MD_DIV:   return ALU_CTL_DIV;
            MD_DIVU:  return ALU_CTL_DIVU;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter: loadable down-counter with a terminal-count flag.
// One instance is shared by the START and WAIT phases of the sequencer;
// tc is high whenever the count has reached zero.
module muldiv_cycle_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: drives multi-cycle MULT/MULTU/DIV/DIVU on ALU_32,
// captures the result into HI/LO and serves MFHI/MFLO reads.
// Optional feature macro: MULDIV_DIVZERO_CHECK_EN -- when defined, DIV/DIVU
// with a zero divisor is caught up front, never reaches the ALU and only
// pulses div_zero; otherwise div_zero is tied low.
module alu_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int START_HOLD = 2,
    parameter int LATENCY    = 34
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic        alu_start,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_buffer,
    output logic        div_zero
);

    localparam int MAX_LOAD = (LATENCY > START_HOLD) ? LATENCY : START_HOLD;
    localparam int CNT_W    = $clog2(MAX_LOAD + 1);

    md_state_e        state;
    md_state_e        state_next;
    logic             accept;
    logic             start_md;
    logic             dz_hit;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_tc;

    assign accept   = op_valid && (state == S_IDLE);
    assign start_md = accept && is_muldiv(op) && !dz_hit;

`ifdef MULDIV_DIVZERO_CHECK_EN
    assign dz_hit = accept && ((op == MD_DIV) || (op == MD_DIVU)) && (rt_val == '0);

    // A zero divisor is reported for one cycle instead of running the ALU.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_zero <= 1'b0;
        end else begin
            div_zero <= dz_hit;
        end
    end
`else
    assign dz_hit   = 1'b0;
    assign div_zero = 1'b0;
`endif

    muldiv_cycle_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (cnt_value),
        .tc         (cnt_tc)
    );

    // Next-state logic; the counter is reloaded on every phase entry.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        case (state)
            S_IDLE: begin
                if (start_md) begin
                    state_next = S_START;
                    cnt_load   = 1'b1;
                    cnt_value  = CNT_W'(START_HOLD - 1);
                end
            end
            S_START: begin
                if (cnt_tc) begin
                    state_next = S_WAIT;
                    cnt_load   = 1'b1;
                    cnt_value  = CNT_W'(LATENCY);
                end
            end
            S_WAIT: begin
                if (cnt_tc) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands and ALU op code are latched on acceptance and held until the next op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
        end else if (start_md) begin
            alu_a       <= rs_val;
            alu_b       <= rt_val;
            alu_control <= alu_ctl_for(op);
        end
    end

    // HI/LO take the ALU outputs on the edge that leaves WAIT, the same edge done rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == S_WAIT) && cnt_tc) begin
            hi <= alu_buffer;
            lo <= alu_result;
        end
    end

    // MFHI/MFLO register the selected value and flag it for one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (accept && (op == MD_MFHI)) begin
                rd_valid <= 1'b1;
                rd_data  <= hi;
            end else if (accept && (op == MD_MFLO)) begin
                rd_valid <= 1'b1;
                rd_data  <= lo;
            end
        end
    end

    assign op_ready  = (state == S_IDLE);
    assign busy      = !op_ready;
    assign alu_start = (state == S_START);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb_alu_muldiv_sequencer: self-checking bench for alu_muldiv_sequencer.
// A behavioural ALU_32 answers only once LATENCY cycles have passed since
// alu_start fell; a schedule-based reference model predicts every output.
// Honours MULDIV_DIVZERO_CHECK_EN when the design is built with it.
module tb_alu_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int SH  = 2;
    localparam int LAT = 34;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        op_ready, busy, done, rd_valid, alu_start, div_zero;
    logic [31:0] rd_data, hi, lo, alu_a, alu_b, alu_result, alu_buffer;
    logic [3:0]  alu_control;

    int total = 0;
    int bad = 0;

    alu_muldiv_sequencer #(
        .START_HOLD (SH),
        .LATENCY    (LAT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_valid    (op_valid),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .op_ready    (op_ready),
        .busy        (busy),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .hi          (hi),
        .lo          (lo),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_start   (alu_start),
        .alu_result  (alu_result),
        .alu_buffer  (alu_buffer),
        .div_zero    (div_zero)
    );

    always #5 clock = ~clock;

    // Mathematical ALU_32 result as {hi, lo}; divide by zero gives q=all ones, r=dividend.
    function automatic logic [63:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        case (ctl)
            ALU_CTL_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            ALU_CTL_MULTU: return {32'd0, a} * {32'd0, b};
            ALU_CTL_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            ALU_CTL_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Op code to ALU control, written from the op table.
    function automatic logic [3:0] ctlOf(input logic [2:0] o);
        case (o)
            3'd1:    return ALU_CTL_MULT;
            3'd2:    return ALU_CTL_MULTU;
            3'd3:    return ALU_CTL_DIV;
            3'd4:    return ALU_CTL_DIVU;
            default: return 4'd0;
        endcase
    endfunction

    // Behavioural ALU: outputs are garbage until LATENCY cycles after alu_start falls.
    int since = 1000;
    always @(negedge clock) begin
        if (alu_start) since <= 0;
        else if (since < 100000) since <= since + 1;
    end
    assign {alu_buffer, alu_result} = (since >= LAT) ? alu_ref(alu_control, alu_a, alu_b)
                                                     : {32'hDEAD_BEEF, 32'hDEAD_BEEF};

    // Reference model: an accepted mul/div at edge E finishes at E+SH+LAT+1, idle at E+SH+LAT+2.
    int          m_edge = 0;
    int          m_acc = 0;
    bit          m_busy = 0;
    bit          m_ready = 1, m_done = 0, m_rdv = 0, m_dz = 0, m_start = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rd = '0, m_a = '0, m_b = '0;
    logic [3:0]  m_ctl = '0;
    logic [63:0] m_pend = '0;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_busy = 0; m_ready = 1; m_done = 0; m_rdv = 0; m_dz = 0; m_start = 0;
                m_hi = '0; m_lo = '0; m_rd = '0; m_a = '0; m_b = '0; m_ctl = '0;
            end else begin
                m_edge++;
                m_done = 0; m_rdv = 0; m_dz = 0;
                if (m_busy) begin
                    if (m_edge == m_acc + SH + LAT + 1) begin
                        m_hi = m_pend[63:32];
                        m_lo = m_pend[31:0];
                        m_done = 1;
                    end else if (m_edge == m_acc + SH + LAT + 2) begin
                        m_busy = 0;
                    end
                end else if (op_valid) begin
                    case (op)
                        3'd1, 3'd2, 3'd3, 3'd4: begin
`ifdef MULDIV_DIVZERO_CHECK_EN
                            if ((op == 3'd3 || op == 3'd4) && rt_val == 0) begin
                                m_dz = 1;
                            end else begin
`else
                            begin
`endif
                                m_busy = 1;
                                m_acc  = m_edge;
                                m_a    = rs_val;
                                m_b    = rt_val;
                                m_ctl  = ctlOf(op);
                                m_pend = alu_ref(m_ctl, rs_val, rt_val);
                            end
                        end
                        3'd5: begin m_rd = m_hi; m_rdv = 1; end
                        3'd6: begin m_rd = m_lo; m_rdv = 1; end
                        default: ;
                    endcase
                end
                m_ready = !m_busy;
                m_start = m_busy && ((m_edge - m_acc) < SH);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge out of reset.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                checkOutput("op_ready", 32'(op_ready), 32'(m_ready));
                checkOutput("busy", 32'(busy), 32'(!m_ready));
                checkOutput("done", 32'(done), 32'(m_done));
                checkOutput("rd_valid", 32'(rd_valid), 32'(m_rdv));
                checkOutput("rd_data", rd_data, m_rd);
                checkOutput("hi", hi, m_hi);
                checkOutput("lo", lo, m_lo);
                checkOutput("alu_start", 32'(alu_start), 32'(m_start));
                checkOutput("div_zero", 32'(div_zero), 32'(m_dz));
                checkOutput("alu_a", alu_a, m_a);
                checkOutput("alu_b", alu_b, m_b);
                checkOutput("alu_control", 32'(alu_control), 32'(m_ctl));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op_valid = v;
        op       = o;
        rs_val   = a;
        rt_val   = b;
    endtask

    task automatic waitReady();
        int i;
        for (i = 0; i < 200; i++) begin
            if (op_ready) break;
            @(posedge clock); #1;
        end
        if (i == 200) checkOutput("ready_timeout", 32'(op_ready), 32'd1);
    endtask

    // Present one op for exactly the accepting edge.
    task automatic issueOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        waitReady();
        applyStimulus(1'b1, o, a, b);
        @(posedge clock); #1;
        op_valid = 1'b0;
    endtask

    // Edges counted from the accepting edge until done is seen; -1 on timeout.
    task automatic waitForDone(input string name, output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock); #1;
            if (done) begin lat = i; break; end
        end
        if (lat < 0) checkOutput({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    int lat;
    bit sawDone;
    bit sawStart;
    bit gotRead;

    initial begin
        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_op_ready", 32'(op_ready), 32'd1);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_alu_start", 32'(alu_start), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // MULT latency and result.
        issueOp(MD_MULT, 32'd100000000, 32'd2000);
        waitForDone("mult", lat);
        checkOutput("mult_latency", 32'(lat), 32'd37);
        checkOutput("mult_hi", hi, 32'h0000_002E);
        checkOutput("mult_lo", lo, 32'h90ED_D000);

        // DIVU then MFLO.
        issueOp(MD_DIVU, 32'd100000000, 32'd2000);
        waitForDone("divu", lat);
        checkOutput("divu_lo", lo, 32'h0000_C350);
        checkOutput("divu_hi", hi, 32'h0000_0000);
        issueOp(MD_MFLO, 32'd0, 32'd0);
        checkOutput("mflo_valid", 32'(rd_valid), 32'd1);
        checkOutput("mflo_data", rd_data, 32'h0000_C350);

        // MFHI held off during WAIT, returns the new hi after done.
        issueOp(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        repeat (SH + 8) @(posedge clock);
        applyStimulus(1'b1, MD_MFHI, 32'd0, 32'd0);
        checkOutput("mfhi_held_off", 32'(op_ready), 32'd0);
        sawDone = 0;
        gotRead = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (done) sawDone = 1;
            if (rd_valid) begin gotRead = 1; break; end
        end
        op_valid = 1'b0;
        checkOutput("mfhi_got_read", 32'(gotRead), 32'd1);
        checkOutput("mfhi_after_done", 32'(sawDone), 32'd1);
        checkOutput("mfhi_data", rd_data, 32'hFFFF_FFFF);

        // Divide by zero.
        issueOp(MD_DIV, 32'd1234, 32'd0);
`ifdef MULDIV_DIVZERO_CHECK_EN
        checkOutput("dz_pulse", 32'(div_zero), 32'd1);
        sawStart = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (alu_start) sawStart = 1;
        end
        checkOutput("dz_no_start", 32'(sawStart), 32'd0);
        checkOutput("dz_hi_kept", hi, 32'hFFFF_FFFF);
        checkOutput("dz_lo_kept", lo, 32'hFFFF_FFFE);
`else
        checkOutput("dz_tied_low", 32'(div_zero), 32'd0);
        waitForDone("div0", lat);
        checkOutput("div0_latency", 32'(lat), 32'd37);
        checkOutput("div0_hi", hi, 32'd1234);
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reserved op codes have no effect.
        waitReady();
        applyStimulus(1'b1, MD_RSVD, 32'd5, 32'd6);
        applyStimulus(1'b1, MD_NONE, 32'd5, 32'd6);
        @(posedge clock); #1;
        op_valid = 1'b0;
        checkOutput("rsvd_ready", 32'(op_ready), 32'd1);
        checkOutput("rsvd_no_read", 32'(rd_valid), 32'd0);

        // Asynchronous reset in WAIT cycle 10.
        issueOp(MD_MULTU, 32'd7, 32'd9);
        repeat (SH + 9) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_alu_start", 32'(alu_start), 32'd0);
        checkOutput("areset_hi", hi, 32'd0);
        checkOutput("areset_lo", lo, 32'd0);
        checkOutput("areset_ready", 32'(op_ready), 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic checked by the model.
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 5000)) : 32'($urandom());
            applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b);
        end
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
        repeat (50) @(posedge clock);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
